l0_pool: RTL and testbench
==========================

Name: l0_pool

Overview:
- 2x2 max-pool stage on the read side of the first convolution layer.
- Runs in lockstep with that layer's window-read sequencer and observes its `rdy` and its registered RAM outputs for both channels.
- Reduces each 4-element window to one maximum per channel; 13x13 = 169 windows per frame.
- Pooled pixels are buffered in a small show-ahead FIFO with a valid/ready interface towards the next layer.

Parameters:
- DATA_WIDTH, 18, width of each channel sample (unsigned, post-ReLU).
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- WIN_PER_FRAME, 169, pooled pixels per frame.
- IDX_WIDTH, 8, width of the pooled pixel index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- tx_done  in  1  frame restart; synchronous clear.
- rdy_in  in  1  producer window-ready (producer's `rdy`).
- din_0  in  DATA_WIDTH  channel 0 RAM read data (registered, 1-cycle latency).
- din_1  in  DATA_WIDTH  channel 1 RAM read data.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  downstream accepts head.
- out_0  out  DATA_WIDTH  pooled max, channel 0.
- out_1  out  DATA_WIDTH  pooled max, channel 1.
- out_idx  out  IDX_WIDTH  pooled pixel index of head, 0..WIN_PER_FRAME-1.
- frame_done  out  1  one-cycle pulse when the last window of a frame is pushed.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; FSM in IDLE; window counter 0; FIFO empty; ovf 0.
- tx_done is a synchronous clear with the same effect as reset. It has priority over every other event in that cycle.

FSM states: IDLE, E0, E1, E2, E3.
- IDLE: if rdy_in=1, go to E0; else stay in IDLE. In this cycle the producer issues the address of element 0.
- E0: load max_0 <= din_0 and max_1 <= din_1 (element 0); go to E1.
- E1: max_c <= max(max_c, din_c) (element 1); go to E2.
- E2: same update (element 2); go to E3.
- E3: final_c = max(max_c, din_c) (element 3); push {final_0, final_1, win_cnt} into the FIFO; go to IDLE.
- rdy_in is ignored outside IDLE. With rdy_in held high, windows repeat every 5 cycles.

Arithmetic:
- Unsigned compare at full DATA_WIDTH; no truncation.
- On equal values the earlier element is kept; the result is the same value either way.

Window counter:
- Increments on every push attempt, whether the push succeeds or is dropped.
- At WIN_PER_FRAME-1 the push pulses frame_done for exactly that cycle (registered, so the pulse appears the cycle after E3) and the counter wraps to 0.

FIFO (show-ahead):
- out_0, out_1, out_idx show the head entry when out_vld=1 and are driven to 0 when the FIFO is empty.
- Pop when out_vld and out_rdy are both 1.
- Latency: a push into an empty FIFO gives out_vld=1 in the cycle after E3.
- Push while full with no pop: the entry is dropped and ovf is set; ovf holds until reset or tx_done.
- Push and pop in the same cycle while full: both succeed, occupancy unchanged, no ovf.
- Push and pop in the same cycle with one entry: the head advances to the new entry and out_vld stays 1.
- Pointers wrap modulo FIFO_DEPTH.

Reset or tx_done mid-window: the partial window is discarded with no push, and the counter returns to 0.

Test Plan:
1. Single window: rdy_in pulse, then din_0 = 5, 9, 3, 7 and din_1 = 0, 0, 0x3FFFF, 1 over E0..E3 -> one cycle after E3: out_vld=1, out_0=9, out_1=0x3FFFF, out_idx=0. With out_rdy=1 the entry pops next cycle and out_vld returns to 0.
2. Full frame: rdy_in held high, din = window number, out_rdy=1 -> 169 outputs with out_idx 0..168 at a spacing of 5 cycles; frame_done pulses once, after the idx-168 push; the next window reports idx 0.
3. Backpressure: out_rdy=0 for 5 windows -> FIFO holds idx 0..3 and ovf=1 after the 5th push (idx 4 dropped). Then out_rdy=1 -> drains 0, 1, 2, 3 in consecutive cycles; ovf stays 1.
4. Full FIFO with out_rdy=1 exactly in the E3 cycle of a window -> head idx 0 pops, the new entry is stored, occupancy stays 4, ovf=0.
5. tx_done asserted in E1 -> FSM back to IDLE, no push, FIFO empty, out_vld=0, ovf=0. The next window reports out_idx=0.
6. Async reset pulse mid-E2 with 2 entries queued -> all outputs 0 immediately and no output until a new rdy_in.

Source files
------------

// File: rtl/l0_pool_if.sv
// rtl/l0_pool_if.sv - pooled-pixel output stream between l0_pool and the next layer
interface l0_pool_if #(
  parameter int DATA_WIDTH = 18,
  parameter int IDX_WIDTH  = 8
);
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_0;
  logic [DATA_WIDTH-1:0] out_1;
  logic [IDX_WIDTH-1:0]  out_idx;

  modport master (
    output out_vld,
    output out_0,
    output out_1,
    output out_idx,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_0,
    input  out_1,
    input  out_idx,
    output out_rdy
  );
endinterface

// File: rtl/l0_pool.sv
// rtl/l0_pool.sv - 2x2 max-pool of the first conv layer read stream into a show-ahead FIFO
module l0_pool #(
  parameter int DATA_WIDTH    = 18,
  parameter int FIFO_DEPTH    = 4,
  parameter int WIN_PER_FRAME = 169,
  parameter int IDX_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_done,
  input  logic                  rdy_in,
  input  logic [DATA_WIDTH-1:0] din_0,
  input  logic [DATA_WIDTH-1:0] din_1,
  l0_pool_if.master             out_if,
  output logic                  frame_done,
  output logic                  ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, E0, E1, E2, E3} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] max_0, max_1;
  logic [DATA_WIDTH-1:0] final_0, final_1;
  logic [IDX_WIDTH-1:0]  win_cnt;
  logic                  win_last;

  logic [DATA_WIDTH-1:0] mem_0   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_1   [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]  mem_idx [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic push, pop, wr_en, full, empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (tx_done) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rdy_in) state_nxt = E0;
      E0:      state_nxt = E1;
      E1:      state_nxt = E2;
      E2:      state_nxt = E3;
      E3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strict greater-than keeps the earlier element on ties.
  assign final_0 = (din_0 > max_0) ? din_0 : max_0;
  assign final_1 = (din_1 > max_1) ? din_1 : max_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_0 <= '0;
      max_1 <= '0;
    end else if (tx_done) begin
      max_0 <= '0;
      max_1 <= '0;
    end else begin
      case (state)
        E0: begin
          max_0 <= din_0;
          max_1 <= din_1;
        end
        E1, E2: begin
          max_0 <= final_0;
          max_1 <= final_1;
        end
        default: ;
      endcase
    end
  end

  assign push     = (state == E3);
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = !empty && out_if.out_rdy;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en    = push && (!full || pop);
  assign win_last = (win_cnt == IDX_WIDTH'(WIN_PER_FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else if (tx_done) begin
      win_cnt    <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= push && win_last;
      if (push) begin
        win_cnt <= win_last ? '0 : win_cnt + IDX_WIDTH'(1);
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_0[wr_ptr]   <= final_0;
      mem_1[wr_ptr]   <= final_1;
      mem_idx[wr_ptr] <= win_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (tx_done) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign out_if.out_vld = !empty;
  assign out_if.out_0   = empty ? '0 : mem_0[rd_ptr];
  assign out_if.out_1   = empty ? '0 : mem_1[rd_ptr];
  assign out_if.out_idx = empty ? '0 : mem_idx[rd_ptr];

endmodule

// File: tb/tb_l0_pool.sv
// tb/tb_l0_pool.sv - self-checking bench for l0_pool
module tb_l0_pool;

  logic        clk;
  logic        rst_n;
  logic        tx_done;
  logic        rdy_in;
  logic [17:0] din_0, din_1;
  logic        frame_done, ovf;

  l0_pool_if #(.DATA_WIDTH(18), .IDX_WIDTH(8)) oif ();

  l0_pool #(
    .DATA_WIDTH(18), .FIFO_DEPTH(4), .WIN_PER_FRAME(169), .IDX_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_done(tx_done), .rdy_in(rdy_in),
    .din_0(din_0), .din_1(din_1), .out_if(oif),
    .frame_done(frame_done), .ovf(ovf)
  );

  typedef struct packed {
    logic [0:3][17:0] a;
    logic [0:3][17:0] b;
    logic [17:0]      e0;
    logic [17:0]      e1;
  } vec_t;

  typedef struct packed {
    logic [17:0] d0;
    logic [17:0] d1;
    logic [7:0]  idx;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[6];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tb_idx = 0;
  int   fd_count = 0;
  int   fd_cyc = 0;
  int   e3_cyc = 0;
  int   last_pop_cyc = 0;
  bit   last_pop_vld = 0;
  bit   spacing_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] max4(input logic [17:0] x0, x1, x2, x3);
    logic [17:0] m;
    m = x0;
    if (x1 > m) m = x1;
    if (x2 > m) m = x2;
    if (x3 > m) m = x3;
    return m;
  endfunction

  function automatic vec_t mk(input logic [17:0] a0, a1, a2, a3, b0, b1, b2, b3, e0, e1);
    vec_t v;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Returns during the E3 cycle of the window.
  task automatic do_window(input logic [17:0] a0, a1, a2, a3, b0, b1, b2, b3,
                           input bit keep, input logic [17:0] e0, e1);
    exp_t e;
    if (keep) begin
      e.d0 = e0; e.d1 = e1; e.idx = 8'(tb_idx);
      sbq.push_back(e);
    end
    tb_idx = (tb_idx == 168) ? 0 : tb_idx + 1;
    @(posedge clk); #1 rdy_in = 1'b1;
    @(posedge clk); #1 rdy_in = 1'b0; din_0 = a0; din_1 = b0;
    @(posedge clk); #1 din_0 = a1; din_1 = b1;
    @(posedge clk); #1 din_0 = a2; din_1 = b2;
    @(posedge clk); #1 din_0 = a3; din_1 = b3;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    sbq.delete();
    tb_idx = 0;
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    if (rst_n && oif.out_vld && oif.out_rdy) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pop", {24'h0, oif.out_idx}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_out_0", {14'h0, oif.out_0}, {14'h0, e.d0});
        chk("sb_out_1", {14'h0, oif.out_1}, {14'h0, e.d1});
        chk("sb_out_idx", {24'h0, oif.out_idx}, {24'h0, e.idx});
      end
      if (spacing_chk && last_pop_vld) chk("pop_spacing", cyc - last_pop_cyc, 5);
      last_pop_cyc = cyc;
      last_pop_vld = 1'b1;
    end
    if (!oif.out_vld) begin
      chk("empty_zero", {oif.out_0, oif.out_1[13:0]} | {24'h0, oif.out_idx}, 32'h0);
    end
  end

  initial begin
    int w;
    logic [17:0] pa[4];
    logic [17:0] pb[4];

    vt[0] = mk(18'd5, 18'd9, 18'd3, 18'd7, 18'd0, 18'd0, 18'h3FFFF, 18'd1, 18'd9, 18'h3FFFF);
    vt[1] = mk(18'd1, 18'd2, 18'd3, 18'd4, 18'd4, 18'd3, 18'd2, 18'd1, 18'd4, 18'd4);
    vt[2] = mk(18'd7, 18'd7, 18'd7, 18'd7, 18'd0, 18'd0, 18'd0, 18'd0, 18'd7, 18'd0);
    vt[3] = mk(18'h20000, 18'h1FFFF, 18'd0, 18'h1FFFF, 18'h3FFFF, 18'h3FFFE, 18'h3FFFF, 18'd0,
               18'h20000, 18'h3FFFF);
    vt[4] = mk(18'd0, 18'd0, 18'd0, 18'd0, 18'h100, 18'h0FF, 18'h101, 18'd0, 18'd0, 18'h101);
    vt[5] = mk(18'h3FFFE, 18'd0, 18'h3FFFF, 18'd1, 18'd1, 18'd2, 18'd0, 18'd2, 18'h3FFFF, 18'd2);

    rst_n = 1'b0; tx_done = 1'b0; rdy_in = 1'b0; din_0 = '0; din_1 = '0;
    oif.out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_vld", {31'h0, oif.out_vld}, 0);
    chk("rst_frame_done", {31'h0, frame_done}, 0);
    chk("rst_ovf", {31'h0, ovf}, 0);
    rst_n = 1'b1;

    // Single window
    do_window(18'd5, 18'd9, 18'd3, 18'd7, 18'd0, 18'd0, 18'h3FFFF, 18'd1, 1'b1, 18'd9, 18'h3FFFF);
    @(negedge clk);
    chk("t1_vld_in_e3", {31'h0, oif.out_vld}, 0);
    @(negedge clk);
    chk("t1_vld", {31'h0, oif.out_vld}, 1);
    chk("t1_out_0", {14'h0, oif.out_0}, 9);
    chk("t1_out_1", {14'h0, oif.out_1}, 32'h3FFFF);
    chk("t1_idx", {24'h0, oif.out_idx}, 0);
    @(negedge clk);
    chk("t1_vld_after_pop", {31'h0, oif.out_vld}, 0);

    // Table of windows
    for (int i = 0; i < 6; i++) begin
      do_window(vt[i].a[0], vt[i].a[1], vt[i].a[2], vt[i].a[3],
                vt[i].b[0], vt[i].b[1], vt[i].b[2], vt[i].b[3], 1'b1, vt[i].e0, vt[i].e1);
      @(negedge clk);
      @(negedge clk);
      chk("tbl_vld", {31'h0, oif.out_vld}, 1);
      chk("tbl_out_0", {14'h0, oif.out_0}, {14'h0, vt[i].e0});
      chk("tbl_out_1", {14'h0, oif.out_1}, {14'h0, vt[i].e1});
      chk("tbl_idx", {24'h0, oif.out_idx}, i + 1);
    end

    // Full frame
    pulse_tx_done();
    fd_count = 0;
    last_pop_vld = 1'b0;
    spacing_chk = 1'b1;
    for (w = 0; w < 170; w++) begin
      for (int k = 0; k < 4; k++) begin
        pa[k] = (k == w % 4) ? 18'(w + 1000) : 18'(w);
        pb[k] = (k == (w + 1) % 4) ? 18'(18'h3FFFF - w) : 18'(w);
      end
      do_window(pa[0], pa[1], pa[2], pa[3], pb[0], pb[1], pb[2], pb[3], 1'b1,
                max4(pa[0], pa[1], pa[2], pa[3]), max4(pb[0], pb[1], pb[2], pb[3]));
      if (w == 168) e3_cyc = cyc;
    end
    repeat (3) @(negedge clk);
    spacing_chk = 1'b0;
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_cycle", fd_cyc, e3_cyc + 1);
    chk("frame_sb_empty", sbq.size(), 0);

    // Backpressure and overflow
    pulse_tx_done();
    oif.out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_window(18'(k), 18'd0, 18'd0, 18'd0, 18'd0, 18'(k), 18'd0, 18'd0, k < 4, 18'(k), 18'(k));
    end
    @(negedge clk);
    chk("bp_ovf_before", {31'h0, ovf}, 0);
    @(posedge clk); #1 oif.out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_ovf_after", {31'h0, ovf}, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_drain_vld", {31'h0, oif.out_vld}, 1);
      chk("bp_drain_idx", {24'h0, oif.out_idx}, k);
    end
    @(negedge clk);
    chk("bp_drained", {31'h0, oif.out_vld}, 0);
    chk("bp_ovf_sticky", {31'h0, ovf}, 1);

    // Full FIFO, pop coincides with push in E3
    pulse_tx_done();
    chk("t4_ovf_cleared", {31'h0, ovf}, 0);
    oif.out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_window(18'(k + 10), 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'(k + 20), 1'b1,
                18'(k + 10), 18'(k + 20));
    end
    oif.out_rdy = 1'b1;
    @(posedge clk); #1 oif.out_rdy = 1'b0;
    @(negedge clk);
    chk("t4_ovf", {31'h0, ovf}, 0);
    chk("t4_vld", {31'h0, oif.out_vld}, 1);
    chk("t4_head", {24'h0, oif.out_idx}, 1);
    @(posedge clk); #1 oif.out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_drain_idx", {24'h0, oif.out_idx}, k + 1);
    end
    @(negedge clk);
    chk("t4_occupancy4", {31'h0, oif.out_vld}, 0);

    // tx_done during E1
    pulse_tx_done();
    oif.out_rdy = 1'b0;
    do_window(18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 18'd1, 1'b1, 18'd1, 18'd1);
    @(posedge clk); #1 rdy_in = 1'b1;
    @(posedge clk); #1 rdy_in = 1'b0; din_0 = 18'd50; din_1 = 18'd50;
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    sbq.delete();
    tb_idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_no_push", {31'h0, oif.out_vld}, 0);
    end
    chk("t5_ovf", {31'h0, ovf}, 0);
    oif.out_rdy = 1'b1;
    do_window(18'd3, 18'd8, 18'd2, 18'd1, 18'd6, 18'd4, 18'd9, 18'd5, 1'b1, 18'd8, 18'd9);
    @(negedge clk);
    @(negedge clk);
    chk("t5_next_idx", {24'h0, oif.out_idx}, 0);
    chk("t5_next_out_0", {14'h0, oif.out_0}, 8);

    // Async reset mid-E2 with two entries queued
    @(negedge clk);
    oif.out_rdy = 1'b0;
    do_window(18'd4, 18'd0, 18'd0, 18'd0, 18'd4, 18'd0, 18'd0, 18'd0, 1'b1, 18'd4, 18'd4);
    do_window(18'd5, 18'd0, 18'd0, 18'd0, 18'd5, 18'd0, 18'd0, 18'd0, 1'b1, 18'd5, 18'd5);
    @(posedge clk); #1 rdy_in = 1'b1;
    @(posedge clk); #1 rdy_in = 1'b0; din_0 = 18'd7; din_1 = 18'd7;
    @(posedge clk); #1 din_0 = 18'd7;
    @(posedge clk); #1 din_0 = 18'd7;
    chk("t6_queued_vld", {31'h0, oif.out_vld}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", {31'h0, oif.out_vld}, 0);
    chk("t6_rst_out_0", {14'h0, oif.out_0}, 0);
    chk("t6_rst_ovf", {31'h0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    tb_idx = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_idle", {31'h0, oif.out_vld}, 0);
    end
    oif.out_rdy = 1'b1;
    do_window(18'd2, 18'd6, 18'd1, 18'd0, 18'd3, 18'd3, 18'd3, 18'd3, 1'b1, 18'd6, 18'd3);
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
